l2_arbiter: RTL and testbench

- Shares the single unified L2 cache port between the L1 instruction-cache and L1 data-cache miss paths.
- Accepts line-granular requests from both L1s and grants one at a time: fixed D-over-I priority with a starvation guard.
- Latches the winner's address and data, and drives the L2 read/write strobes until the L2 returns its one-cycle response.
- Routes the response and read line back to the granted requester only.

---
 rtl/l2_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_l2_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_arbiter.sv
// l2_arbiter: shares the unified L2 port between the L1 I-cache and D-cache miss paths.
//
// One line-granular request is granted at a time. D wins over I, but after
// STARVE_MAX back-to-back D grants with I waiting, I is forced to win. The winner's
// address (and writeback line) is latched, and the L2 strobe is held until
// l2_resp. The response goes back to the granted side only. One DRAIN cycle
// follows every transfer before the next arbitration.
//
// Ports:
//   clk, rst                  clock; synchronous active-low reset
//   i_read, i_addr            I-cache line read request (held until i_resp)
//   i_resp, i_rdata           I-side one-cycle completion and returned line
//   d_read, d_write, d_addr   D-cache read / writeback request (held until d_resp)
//   d_wdata                   D-cache writeback line
//   d_resp, d_rdata           D-side one-cycle completion and returned line
//   l2_read, l2_write         registered strobes to L2
//   l2_addr, l2_wdata         latched address / write line to L2
//   l2_resp, l2_rdata         one-cycle L2 completion and read line
//
// Optional macro L2_ARB_PERF_EN adds saturating 32-bit counters:
//   perf_i_grants, perf_d_grants, perf_wait_cycles.

module l2_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LINE_W     = 256,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic              l2_resp,
  input  logic [LINE_W-1:0] l2_rdata
`ifdef L2_ARB_PERF_EN
  ,
  output logic [31:0]       perf_i_grants,
  output logic [31:0]       perf_d_grants,
  output logic [31:0]       perf_wait_cycles
`endif
);

  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StGrantI, StGrantD, StDrain} state_e;

  state_e              r_state, w_state_d;
  logic [StarveW-1:0]  r_starve, w_starve_d;
  logic                r_l2_read, w_l2_read_d;
  logic                r_l2_write, w_l2_write_d;
  logic [ADDR_W-1:0]   r_l2_addr, w_l2_addr_d;
  logic [LINE_W-1:0]   r_l2_wdata, w_l2_wdata_d;

  logic w_d_req;
  logic w_grant_d;
  logic w_grant_i;
  logic w_done;

  always_comb begin
    w_d_req   = d_read | d_write;
    w_grant_d = (r_state == StIdle) && w_d_req && (!i_read || (r_starve < StarveMax));
    w_grant_i = (r_state == StIdle) && !w_grant_d && i_read;
    w_done    = ((r_state == StGrantI) || (r_state == StGrantD)) && l2_resp;
  end

  // Next-state, latched operation and starve counter
  always_comb begin
    w_state_d    = r_state;
    w_starve_d   = r_starve;
    w_l2_read_d  = r_l2_read;
    w_l2_write_d = r_l2_write;
    w_l2_addr_d  = r_l2_addr;
    w_l2_wdata_d = r_l2_wdata;

    unique case (r_state)
      StIdle: begin
        if (w_grant_d) begin
          w_state_d    = StGrantD;
          // A simultaneous read and write is treated as the write alone
          w_l2_write_d = d_write;
          w_l2_read_d  = !d_write;
          w_l2_addr_d  = d_addr;
          if (d_write) begin
            w_l2_wdata_d = d_wdata;
          end
        end else if (w_grant_i) begin
          w_state_d    = StGrantI;
          w_l2_read_d  = 1'b1;
          w_l2_write_d = 1'b0;
          w_l2_addr_d  = i_addr;
        end
      end
      StGrantI, StGrantD: begin
        if (l2_resp) begin
          w_state_d    = StDrain;
          w_l2_read_d  = 1'b0;
          w_l2_write_d = 1'b0;
        end
      end
      StDrain: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase

    if (w_grant_i) begin
      w_starve_d = '0;
    end else if (w_grant_d && i_read) begin
      if (r_starve != StarveMax) begin
        w_starve_d = r_starve + 1'b1;
      end
    end else if ((r_state == StIdle) && !i_read) begin
      w_starve_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_starve   <= '0;
      r_l2_read  <= 1'b0;
      r_l2_write <= 1'b0;
      r_l2_addr  <= '0;
      r_l2_wdata <= '0;
    end else begin
      r_state    <= w_state_d;
      r_starve   <= w_starve_d;
      r_l2_read  <= w_l2_read_d;
      r_l2_write <= w_l2_write_d;
      r_l2_addr  <= w_l2_addr_d;
      r_l2_wdata <= w_l2_wdata_d;
    end
  end

  // Responses are combinational off l2_resp; gated by rst so reset forces them low
  always_comb begin
    i_resp   = rst && w_done && (r_state == StGrantI);
    d_resp   = rst && w_done && (r_state == StGrantD);
    i_rdata  = (i_resp && r_l2_read) ? l2_rdata : '0;
    d_rdata  = (d_resp && r_l2_read) ? l2_rdata : '0;
    l2_read  = r_l2_read;
    l2_write = r_l2_write;
    l2_addr  = r_l2_addr;
    l2_wdata = r_l2_wdata;
  end

`ifdef L2_ARB_PERF_EN
  logic [31:0] r_perf_i, r_perf_d, r_perf_wait;
  logic        w_any_req;

  always_comb begin
    w_any_req = i_read | d_read | d_write;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perf_i    <= '0;
      r_perf_d    <= '0;
      r_perf_wait <= '0;
    end else begin
      if (w_grant_i && (r_perf_i != '1)) begin
        r_perf_i <= r_perf_i + 32'd1;
      end
      if (w_grant_d && (r_perf_d != '1)) begin
        r_perf_d <= r_perf_d + 32'd1;
      end
      if (w_any_req && (r_state != StIdle) && (r_perf_wait != '1)) begin
        r_perf_wait <= r_perf_wait + 32'd1;
      end
    end
  end

  always_comb begin
    perf_i_grants    = r_perf_i;
    perf_d_grants    = r_perf_d;
    perf_wait_cycles = r_perf_wait;
  end
`endif

endmodule

// File: tb/tb_l2_arbiter.sv
// Scoreboard bench for l2_arbiter: stimulus pushes expected grants and responses,
// a negedge monitor pops and compares whenever the DUT grants or responds.
module tb_l2_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  typedef struct {
    bit                rd;
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } grant_t;

  typedef struct {
    bit                side;   // 0 = I, 1 = D
    logic [LINE_W-1:0] rdata;
    int                strobe_cyc;
  } resp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              i_read = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic              i_resp;
  logic [LINE_W-1:0] i_rdata;
  logic              d_read = 1'b0;
  logic              d_write = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [LINE_W-1:0] d_wdata = '0;
  logic              d_resp;
  logic [LINE_W-1:0] d_rdata;
  logic              l2_read;
  logic              l2_write;
  logic [ADDR_W-1:0] l2_addr;
  logic [LINE_W-1:0] l2_wdata;
  logic              l2_resp = 1'b0;
  logic [LINE_W-1:0] l2_rdata = '0;
`ifdef L2_ARB_PERF_EN
  logic [31:0]       perf_i_grants;
  logic [31:0]       perf_d_grants;
  logic [31:0]       perf_wait_cycles;
`endif

  l2_arbiter #(
    .ADDR_W    (ADDR_W),
    .LINE_W    (LINE_W),
    .STARVE_MAX(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_read  (i_read),
    .i_addr  (i_addr),
    .i_resp  (i_resp),
    .i_rdata (i_rdata),
    .d_read  (d_read),
    .d_write (d_write),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_resp  (d_resp),
    .d_rdata (d_rdata),
    .l2_read (l2_read),
    .l2_write(l2_write),
    .l2_addr (l2_addr),
    .l2_wdata(l2_wdata),
    .l2_resp (l2_resp),
    .l2_rdata(l2_rdata)
`ifdef L2_ARB_PERF_EN
    ,
    .perf_i_grants   (perf_i_grants),
    .perf_d_grants   (perf_d_grants),
    .perf_wait_cycles(perf_wait_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int resp_cnt = 0;
  int i_cyc    = 0;
  int d_cyc    = 0;
  int l2_lat   = 1;
  int l2_cnt   = 0;
  bit l2_force = 1'b0;

  grant_t gq[$];
  resp_t  rq[$];

  task automatic check(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // L2 model: answers after l2_lat strobe-high cycles, or immediately when forced
  initial begin
    forever begin
      @(posedge clk);
      #2;
      l2_resp = 1'b0;
      if (l2_force) begin
        l2_resp = 1'b1;
      end else if (l2_read || l2_write) begin
        l2_cnt++;
        if (l2_cnt == l2_lat) begin
          l2_resp = 1'b1;
          l2_cnt  = 0;
        end
      end else begin
        l2_cnt = 0;
      end
    end
  end

  // Monitor
  bit prev_strobe = 1'b0;
  int run = 0;
  always @(negedge clk) begin
    if (!rst) begin
      prev_strobe = 1'b0;
      run = 0;
    end else begin
      if (l2_read || l2_write) begin
        if (!prev_strobe) begin
          run = 0;
          if (gq.size() == 0) begin
            check("unexpected_grant", 1'b1, 1'b0);
          end else begin
            grant_t g;
            g = gq.pop_front();
            check("grant_l2_read", l2_read, g.rd);
            check("grant_l2_write", l2_write, g.wr);
            check("grant_l2_addr", l2_addr, g.addr);
            if (g.wr) check("grant_l2_wdata", l2_wdata, g.wdata);
          end
        end
        run++;
      end
      if (i_resp || d_resp) begin
        if (i_resp && d_resp) begin
          check("both_resp", 1'b1, 1'b0);
        end else if (rq.size() == 0) begin
          check("unexpected_resp", {i_resp, d_resp}, 2'b00);
        end else begin
          resp_t r;
          r = rq.pop_front();
          check("resp_side", d_resp, r.side);
          check("resp_rdata", d_resp ? d_rdata : i_rdata, r.rdata);
          check("strobe_cycles", run, r.strobe_cyc);
        end
        if (i_resp) i_cyc = cyc;
        if (d_resp) d_cyc = cyc;
        resp_cnt++;
      end
      if (!i_resp) check("i_rdata_idle", i_rdata, '0);
      if (!d_resp) check("d_rdata_idle", d_rdata, '0);
      prev_strobe = l2_read || l2_write;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_resps(input int target, input int budget);
    int k = 0;
    while (resp_cnt < target && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (resp_cnt < target) check("resp_timeout", resp_cnt, target);
  endtask

  task automatic push(input bit side, input bit wr, input logic [ADDR_W-1:0] addr,
                      input logic [LINE_W-1:0] wdata, input logic [LINE_W-1:0] line,
                      input int lat);
    grant_t g;
    resp_t  r;
    g.rd = !wr; g.wr = wr; g.addr = addr; g.wdata = wdata;
    gq.push_back(g);
    r.side = side; r.rdata = wr ? '0 : line; r.strobe_cyc = lat;
    rq.push_back(r);
  endtask

  // One isolated transaction from start to DRAIN
  task automatic do_txn(input bit side, input bit rd, input bit wr,
                        input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] wdata,
                        input logic [LINE_W-1:0] line, input int lat);
    int base = resp_cnt;
    l2_lat = lat;
    l2_rdata = line;
    push(side, wr, addr, wdata, line, lat);
    if (side) begin
      d_read = rd; d_write = wr; d_addr = addr; d_wdata = wdata;
    end else begin
      i_read = 1'b1; i_addr = addr;
    end
    wait_resps(base + 1, lat + 20);
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    tick(2);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LINE_W-1:0] a5, l3, w1, w2, w3;
    int base;
    a5 = {32{8'hA5}};
    l3 = {8{32'h3C3C_0001}};
    w1 = {8{32'hDEAD_BEEF}};
    w2 = {8{32'h1234_5678}};
    w3 = {8{32'h0F0F_0F0F}};

    // Reset state
    tick(3);
    @(negedge clk);
    check("rst_i_resp", i_resp, 1'b0);
    check("rst_d_resp", d_resp, 1'b0);
    check("rst_l2_read", l2_read, 1'b0);
    check("rst_l2_write", l2_write, 1'b0);
    check("rst_l2_addr", l2_addr, '0);
    check("rst_l2_wdata", l2_wdata, '0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick(1);

    // Lone I read, L2 latency 3
    do_txn(1'b0, 1'b1, 1'b0, 32'h0000_1000, '0, a5, 3);

    // I and D write together: D first, then I after DRAIN + IDLE + 3 L2 cycles
    base = resp_cnt;
    l2_lat = 3;
    l2_rdata = a5;
    push(1'b1, 1'b1, 32'h0000_2000, w1, a5, 3);
    push(1'b0, 1'b0, 32'h0000_1040, '0, a5, 3);
    d_write = 1'b1; d_addr = 32'h0000_2000; d_wdata = w1;
    i_read = 1'b1; i_addr = 32'h0000_1040;
    wait_resps(base + 1, 30);
    d_write = 1'b0;
    wait_resps(base + 2, 30);
    i_read = 1'b0;
    check("i_after_d_gap", i_cyc - d_cyc, 5);
    tick(2);

    // Starvation: D,D,D,D,I then counter restarts: D,D,D,D,I
    base = resp_cnt;
    l2_lat = 1;
    l2_rdata = l3;
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9) push(1'b0, 1'b0, 32'h0000_3040, '0, l3, 1);
      else push(1'b1, 1'b0, 32'h0000_3000, '0, l3, 1);
    end
    d_read = 1'b1; d_addr = 32'h0000_3000;
    i_read = 1'b1; i_addr = 32'h0000_3040;
    wait_resps(base + 10, 200);
    d_read = 1'b0; i_read = 1'b0;
    tick(2);

    // Read and write together: write wins, d_rdata stays 0
    do_txn(1'b1, 1'b1, 1'b1, 32'h0000_4000, w2, l3, 2);

    // Reset in the middle of GRANT_D, L2 answers the cycle after
    l2_lat = 100;
    gq.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h0000_5000, wdata: '0});
    d_read = 1'b1; d_addr = 32'h0000_5000;
    tick(2);
    rst = 1'b0;
    tick(1);
    rst = 1'b1; d_read = 1'b0; l2_force = 1'b1;
    @(negedge clk);
    check("abort_d_resp", d_resp, 1'b0);
    check("abort_l2_read", l2_read, 1'b0);
    check("abort_l2_write", l2_write, 1'b0);
    check("abort_l2_addr", l2_addr, '0);
    @(posedge clk);
    #1;
    l2_force = 1'b0;
    tick(1);
    do_txn(1'b1, 1'b0, 1'b1, 32'h0000_5040, w3, l3, 2);

`ifdef L2_ARB_PERF_EN
    apply_reset();
    check("perf_rst_i", perf_i_grants, '0);
    check("perf_rst_d", perf_d_grants, '0);
    check("perf_rst_wait", perf_wait_cycles, '0);
    for (int k = 0; k < 3; k++) do_txn(1'b0, 1'b1, 1'b0, 32'h100 * k, '0, a5, 1);
    for (int k = 0; k < 2; k++) do_txn(1'b1, 1'b1, 1'b0, 32'h200 * k, '0, l3, 1);
    check("perf_i_grants", perf_i_grants, 32'd3);
    check("perf_d_grants", perf_d_grants, 32'd2);
    check("perf_wait", perf_wait_cycles, 32'd5);
    apply_reset();
    check("perf_clr_i", perf_i_grants, '0);
    check("perf_clr_d", perf_d_grants, '0);
    check("perf_clr_wait", perf_wait_cycles, '0);
`else
    apply_reset();
`endif

    check("grant_queue_empty", gq.size(), 0);
    check("resp_queue_empty", rq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
